mem_stage_lsu: RTL and testbench

//  Memory-stage load/store unit. It consumes the M-stage controls produced by the

---
 rtl/mem_stage_lsu.sv | 214 +++++++++++++++++++++
 tb/tb_mem_stage_lsu.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit: turns M-stage load/store controls into a
// req/ack transaction on a word-wide data port, builds store byte lanes,
// extracts and extends load data, stalls while busy, and flags misaligned
// accesses and bus timeouts.
module mem_stage_lsu #(
    parameter int AW      = 30,
    parameter int TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          memtoregM,
    input  logic [1:0]    memwriteM,
    input  logic          halfM,
    input  logic          bM,
    input  logic          bunsignedM,
    input  logic [31:0]   aluoutM,
    input  logic [31:0]   writedataM,
    output logic [31:0]   readdataM,
    output logic          stallM,
    output logic          misalignM,
    output logic          buserrM,
    output logic          mem_req,
    output logic          mem_we,
    output logic [3:0]    mem_be,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata,
    input  logic          mem_ack
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    localparam int            CW       = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] TMO_MAX  = CW'(TIMEOUT);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);

    // Byte enables for a store of the given size at the given byte offset.
    function automatic logic [3:0] store_be(input logic [1:0] sz, input logic [1:0] off);
        logic [3:0] be;
        case (sz)
            SZ_BYTE: be = 4'b0001 << off;
            SZ_HALF: be = off[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Replicate the store datum across every lane it could occupy.
    function automatic logic [31:0] store_wdata(input logic [1:0] sz, input logic [31:0] wd);
        logic [31:0] w;
        case (sz)
            SZ_BYTE: w = {4{wd[7:0]}};
            SZ_HALF: w = {2{wd[15:0]}};
            default: w = wd;
        endcase
        return w;
    endfunction

    // Pick the addressed byte/half out of the word and extend it.
    function automatic logic [31:0] load_extract(input logic [1:0] sz, input logic [1:0] off,
                                                 input logic uns, input logic [31:0] rd);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (off)
            2'd0:    b = rd[7:0];
            2'd1:    b = rd[15:8];
            2'd2:    b = rd[23:16];
            default: b = rd[31:24];
        endcase
        h = off[1] ? rd[31:16] : rd[15:0];
        case (sz)
            SZ_BYTE: r = uns ? {24'd0, b} : {{24{b[7]}}, b};
            SZ_HALF: r = uns ? {16'd0, h} : {{16{h[15]}}, h};
            default: r = rd;
        endcase
        return r;
    endfunction

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          we_q, we_d;
    logic [3:0]    be_q, be_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [1:0]    size_q, size_d;
    logic [1:0]    off_q, off_d;
    logic          uns_q, uns_d;
    logic [31:0]   rd_q, rd_d;
    logic          berr_q, berr_d;

    logic          valid_s;
    logic [1:0]    size_s;
    logic          misal_s;
    logic          issue_s;
    logic          unused_s;

    // memwriteM[1] is reserved and deliberately ignored.
    assign unused_s = memwriteM[1];

    assign valid_s = memtoregM | memwriteM[0];
    assign size_s  = bM ? SZ_BYTE : (halfM ? SZ_HALF : SZ_WORD);
    assign misal_s = ((size_s == SZ_HALF) && aluoutM[0]) ||
                     ((size_s == SZ_WORD) && (aluoutM[1:0] != 2'b00));
    assign issue_s = (state_q == ST_IDLE) && valid_s && !misal_s;

    // Stall covers the accepting IDLE cycle plus every REQ cycle; both
    // combinational flags are forced low while reset is held.
    assign stallM    = reset & (issue_s || (state_q == ST_REQ));
    assign misalignM = reset & (state_q == ST_IDLE) & valid_s & misal_s;
    assign buserrM   = berr_q;
    assign readdataM = rd_q;
    assign mem_req   = (state_q == ST_REQ);
    assign mem_we    = we_q;
    assign mem_be    = be_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    // Next-state logic: capture the request, wait for ack or timeout, then release.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        be_d    = be_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        size_d  = size_q;
        off_d   = off_q;
        uns_d   = uns_q;
        rd_d    = rd_q;
        berr_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (issue_s) begin
                    state_d = ST_REQ;
                    cnt_d   = CNT_ZERO;
                    we_d    = memwriteM[0];
                    be_d    = memwriteM[0] ? store_be(size_s, aluoutM[1:0]) : 4'b1111;
                    addr_d  = aluoutM[AW+1:2];
                    wdata_d = store_wdata(size_s, writedataM);
                    size_d  = size_s;
                    off_d   = aluoutM[1:0];
                    uns_d   = bunsignedM;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (mem_ack) begin
                    state_d = ST_DONE;
                    if (!we_q) begin
                        rd_d = load_extract(size_q, off_q, uns_q, mem_rdata);
                    end else begin
                        rd_d = rd_q;
                    end
                end else if (cnt_q >= TMO_LAST) begin
                    state_d = ST_DONE;
                    berr_d  = 1'b1;
                    rd_d    = 32'd0;
                end else begin
                    if (cnt_q != TMO_MAX) begin
                        cnt_d = cnt_q + CNT_ONE;
                    end else begin
                        cnt_d = cnt_q;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and captured-request registers; reset abandons any access in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= CNT_ZERO;
            we_q    <= 1'b0;
            be_q    <= 4'b0000;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            size_q  <= SZ_BYTE;
            off_q   <= 2'b00;
            uns_q   <= 1'b0;
            rd_q    <= 32'd0;
            berr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            be_q    <= be_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            size_q  <= size_d;
            off_q   <= off_d;
            uns_q   <= uns_d;
            rd_q    <= rd_d;
            berr_q  <= berr_d;
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Scoreboard bench for mem_stage_lsu: directed accesses push expected
// request fields and responses into queues; monitors pop and compare.
module tb_mem_stage_lsu;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        memtoregM = 1'b0;
    logic [1:0]  memwriteM = 2'b00;
    logic        halfM = 1'b0;
    logic        bM = 1'b0;
    logic        bunsignedM = 1'b0;
    logic [31:0] aluoutM = 32'd0;
    logic [31:0] writedataM = 32'd0;
    logic [31:0] readdataM;
    logic        stallM, misalignM, buserrM;
    logic        mem_req, mem_we;
    logic [3:0]  mem_be;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'd0;
    logic        mem_ack = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic        we;
        logic [3:0]  be;
        logic [29:0] addr;
        logic [31:0] wd;
    } req_t;

    typedef struct {
        logic        mis;
        logic        berr;
        logic [31:0] rd;
        int          stall;
    } resp_t;

    req_t  req_q[$];
    resp_t resp_q[$];

    mem_stage_lsu #(.AW(30), .TIMEOUT(16)) dut (
        .clk(clk), .reset(reset),
        .memtoregM(memtoregM), .memwriteM(memwriteM), .halfM(halfM), .bM(bM),
        .bunsignedM(bunsignedM), .aluoutM(aluoutM), .writedataM(writedataM),
        .readdataM(readdataM), .stallM(stallM), .misalignM(misalignM), .buserrM(buserrM),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Request monitor: compare captured fields on each rising mem_req.
    logic req_prev = 1'b0;
    always @(negedge clk) begin
        if (!reset) begin
            req_prev = 1'b0;
        end else begin
            if (mem_req && !req_prev) begin
                if (req_q.size() == 0) begin
                    check("unexpected_req", 64'd1, 64'd0);
                end else begin
                    req_t e;
                    e = req_q.pop_front();
                    check("req_we", {63'd0, mem_we}, {63'd0, e.we});
                    check("req_be", {60'd0, mem_be}, {60'd0, e.be});
                    check("req_addr", {34'd0, mem_addr}, {34'd0, e.addr});
                    if (e.we) check("req_wdata", {32'd0, mem_wdata}, {32'd0, e.wd});
                end
            end
            req_prev = mem_req;
        end
    end

    // Response monitor: a response is a misalign pulse or the first unstalled cycle.
    logic stall_prev = 1'b0;
    int   stall_cnt = 0;
    always @(negedge clk) begin
        if (!reset) begin
            stall_prev = 1'b0;
            stall_cnt  = 0;
        end else begin
            if (stallM) stall_cnt++;
            if (misalignM || (stall_prev && !stallM)) begin
                if (resp_q.size() == 0) begin
                    check("unexpected_resp", 64'd1, 64'd0);
                end else begin
                    resp_t e;
                    e = resp_q.pop_front();
                    check("resp_misalign", {63'd0, misalignM}, {63'd0, e.mis});
                    check("resp_buserr", {63'd0, buserrM}, {63'd0, e.berr});
                    check("resp_readdata", {32'd0, readdataM}, {32'd0, e.rd});
                    check("resp_stall_cycles", 64'(stall_cnt), 64'(e.stall));
                end
                stall_cnt = 0;
            end else if (buserrM) begin
                check("stray_buserr", 64'd1, 64'd0);
            end
            stall_prev = stallM;
        end
    end

    task automatic drop_inputs();
        memtoregM = 1'b0; memwriteM = 2'b00; halfM = 1'b0; bM = 1'b0;
        bunsignedM = 1'b0; aluoutM = 32'd0; writedataM = 32'd0;
    endtask

    // One access; ack_after = number of ackless REQ cycles before ack (<0: never).
    task automatic access(input logic ld, input logic st, input logic hf, input logic by,
                          input logic un, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] rd, input int ack_after,
                          input logic [3:0] exp_be, input logic [31:0] exp_wd,
                          input logic [31:0] exp_rd, input logic exp_berr, input int exp_stall);
        int  n;
        bit  done;
        req_t  rq;
        resp_t rs;
        rq.we = st; rq.be = exp_be; rq.addr = addr[31:2]; rq.wd = exp_wd;
        rs.mis = 1'b0; rs.berr = exp_berr; rs.rd = exp_rd; rs.stall = exp_stall;
        req_q.push_back(rq);
        resp_q.push_back(rs);
        @(posedge clk); #1;
        memtoregM = ld; memwriteM = {1'b0, st}; halfM = hf; bM = by; bunsignedM = un;
        aluoutM = addr; writedataM = wd;
        @(posedge clk); #1;
        n = 0;
        done = 1'b0;
        while (!done) begin
            if (n == ack_after) begin
                mem_ack = 1'b1;
                mem_rdata = rd;
            end
            @(posedge clk); #1;
            mem_ack = 1'b0;
            mem_rdata = 32'h5A5A_A5A5;
            n++;
            if (!stallM) begin
                done = 1'b1;
            end else if (n > 100) begin
                check("access_cycle_bound", 64'd1, 64'd0);
                done = 1'b1;
            end
        end
        drop_inputs();
    endtask

    task automatic misaligned(input logic hf, input logic by, input logic [31:0] addr,
                              input logic [31:0] exp_rd);
        resp_t rs;
        rs.mis = 1'b1; rs.berr = 1'b0; rs.rd = exp_rd; rs.stall = 0;
        resp_q.push_back(rs);
        @(posedge clk); #1;
        memtoregM = 1'b1; halfM = hf; bM = by; aluoutM = addr;
        @(posedge clk); #1;
        drop_inputs();
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end");
        $fatal(1, "watchdog");
    end

    initial begin
        req_t rq;
        #1;
        check("reset_outputs",
              {readdataM, stallM, misalignM, buserrM, mem_req, mem_we, mem_be, 23'd0},
              64'd0);
        check("reset_bus", {mem_addr, mem_wdata, 2'b00}, 64'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        // ld st hf by un addr wd rd ack | be wd | rd berr stall
        access(1,0,0,1,0, 32'h0000_1003, 32'h0, 32'h80FF_1234, 0, 4'b1111, 32'h0, 32'hFFFF_FF80, 0, 2);
        access(1,0,1,0,1, 32'h0000_2002, 32'h0, 32'h8001_7FFF, 0, 4'b1111, 32'h0, 32'h0000_8001, 0, 2);
        access(1,0,1,0,0, 32'h0000_2002, 32'h0, 32'h8001_7FFF, 0, 4'b1111, 32'h0, 32'hFFFF_8001, 0, 2);
        access(1,0,1,0,0, 32'h0000_2000, 32'h0, 32'h8001_7FFF, 0, 4'b1111, 32'h0, 32'h0000_7FFF, 0, 2);
        access(1,0,0,1,1, 32'h0000_2001, 32'h0, 32'h8001_7FFF, 0, 4'b1111, 32'h0, 32'h0000_007F, 0, 2);
        access(1,0,0,1,1, 32'h0000_2003, 32'h0, 32'h8001_7FFF, 0, 4'b1111, 32'h0, 32'h0000_0080, 0, 2);
        access(0,1,0,1,0, 32'h0000_3001, 32'h0000_00AB, 32'hFFFF_FFFF, 0, 4'b0010, 32'hABAB_ABAB, 32'h0000_0080, 0, 2);
        access(0,1,1,0,0, 32'h0000_3002, 32'h1234_CDEF, 32'hFFFF_FFFF, 0, 4'b1100, 32'hCDEF_CDEF, 32'h0000_0080, 0, 2);
        access(0,1,1,0,0, 32'h0000_3000, 32'h1234_CDEF, 32'hFFFF_FFFF, 0, 4'b0011, 32'hCDEF_CDEF, 32'h0000_0080, 0, 2);
        access(0,1,0,0,0, 32'h0000_3004, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 2, 4'b1111, 32'hDEAD_BEEF, 32'h0000_0080, 0, 4);
        access(1,1,0,1,0, 32'h0000_3008, 32'h0000_005A, 32'hFFFF_FFFF, 0, 4'b0001, 32'h5A5A_5A5A, 32'h0000_0080, 0, 2);

        misaligned(1'b0, 1'b0, 32'h0000_3002, 32'h0000_0080);
        misaligned(1'b1, 1'b0, 32'h0000_3001, 32'h0000_0080);

        access(1,0,0,0,0, 32'h0000_5000, 32'h0, 32'h1111_1111, -1, 4'b1111, 32'h0, 32'h0000_0000, 1, 17);
        access(1,0,0,0,0, 32'h0000_5004, 32'h0, 32'h1234_5678, 1, 4'b1111, 32'h0, 32'h1234_5678, 0, 3);

        // Reset in the third REQ cycle of a never-acked load: no response expected.
        rq.we = 1'b0; rq.be = 4'b1111; rq.addr = 30'h0000_1800; rq.wd = 32'h0;
        req_q.push_back(rq);
        @(posedge clk); #1;
        memtoregM = 1'b1; aluoutM = 32'h0000_6000;
        repeat (3) @(posedge clk);
        #1;
        check("pre_reset_req", {63'd0, mem_req}, 64'd1);
        reset = 1'b0;
        drop_inputs();
        #1;
        check("mid_reset_req", {63'd0, mem_req}, 64'd0);
        check("mid_reset_stall", {63'd0, stallM}, 64'd0);
        check("mid_reset_readdata", {32'd0, readdataM}, 64'd0);
        @(posedge clk); #1 reset = 1'b1;

        access(1,0,0,0,0, 32'h0000_7000, 32'h0, 32'hCAFE_F00D, 0, 4'b1111, 32'h0, 32'hCAFE_F00D, 0, 2);

        repeat (3) @(posedge clk);
        #1;
        check("req_queue_empty", 64'(req_q.size()), 64'd0);
        check("resp_queue_empty", 64'(resp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
